reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 The module SHALL have parameter WB_BYPASS, default 1: when 1, a register retiring its last pending write in the current cycle counts as not busy for that cycle's hazard check.
REQ-002 The module SHALL have parameter CNT_W, default 2: width of each per-register pending-write counter.
REQ-003 Port clk, input, 1: single clock, rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port issue_valid, input, 1: the decode stage presents an instruction.
REQ-006 Port issue_opcode, input, 7: opcode of the presented instruction.
REQ-007 Port issue_rs1, input, 5: rs1 field.
REQ-008 Port issue_rs2, input, 5: rs2 field.
REQ-009 Port issue_rd, input, 5: rd field.
REQ-010 Port issue_rd_en, input, 1: destination-write qualifier from the existing rd-enable decoder.
REQ-011 Port wb_valid, input, 1: a register-file write retires this cycle.
REQ-012 Port wb_rd, input, 5: register being retired.
REQ-013 Port flush, input, 1: discard all in-flight writes.
REQ-014 Port stall, output, 1: the presented instruction cannot issue this cycle.
REQ-015 Port issue_fire, output, 1: the instruction issues this cycle, defined as issue_valid AND NOT stall.
REQ-016 Port busy_vec, output, 32: bit i is set when counter i is non-zero.

Function
REQ-017 Source usage SHALL be decoded from the opcode as follows.
- R, S and B types: rs1 and rs2 used.
- I, LOAD and JALR types: rs1 only.
- J, LUI, AUIPC and any other opcode: neither source used.
REQ-018 A used source SHALL be hazardous when its counter is non-zero, except in these cases.
- Register x0 is never hazardous.
- With WB_BYPASS=1, a source is not hazardous when wb_valid=1, wb_rd matches it and its counter equals 1.
REQ-019 stall SHALL be asserted when issue_valid=1 and any of the following holds.
- A used source is hazardous.
- issue_rd_en=1 and the counter of issue_rd is at its maximum, 2^CNT_W-1.
REQ-020 stall SHALL be combinational, with zero latency, and SHALL be 0 when issue_valid=0.
REQ-021 The counter of issue_rd SHALL be incremented on issue_fire with issue_rd_en=1 and issue_rd!=0.
REQ-022 The counter of wb_rd SHALL be decremented on wb_valid=1 when wb_rd!=0 and the counter is non-zero.
REQ-023 A decrement of a counter that is already zero SHALL be ignored, and sticky output wb_underflow (1 bit) SHALL be set until reset.
REQ-024 An increment and a decrement hitting the same register in the same cycle SHALL leave its counter unchanged.
REQ-025 Counter updates SHALL be visible on busy_vec and in hazard checks from the next cycle.
REQ-026 flush=1 SHALL clear all counters at the next edge, overriding any increment or decrement in that cycle.
REQ-027 issue_fire SHALL still be reported during a flush cycle, but the issued write SHALL NOT be counted.
REQ-028 Counter 0 and busy_vec[0] SHALL remain 0 at all times.

Reset
REQ-029 While rst_n=0, all counters SHALL be 0, busy_vec SHALL be 0 and wb_underflow SHALL be 0, independent of clk.
REQ-030 stall and issue_fire SHALL follow their combinational definitions during and after reset, with busy values of 0.
REQ-031 Deassertion of rst_n mid-stream SHALL resume with an empty scoreboard; retirements of writes issued before reset are treated as underflow.

Structure
REQ-032 The opcode constants (R_TYPE, I_TYPE, LOAD_TYPE, S_TYPE, B_TYPE, J_TYPE, JALR_TYPE, LUI_TYPE, AUIPC_TYPE) SHALL come from the shared utils package and SHALL NOT be redefined locally.
REQ-033 Source-usage decoding SHALL be a combinational sub-module rs_enabled, with ports opcode, rs1, rs2, rs1_enable and rs2_enable; an x0 source yields enable 0.
REQ-034 The counters SHALL be a single array of 32 CNT_W-bit registers in one always_ff block with asynchronous reset.

Verification
REQ-035 Reset: assert rst_n=0 mid-cycle -> busy_vec=0 immediately; after release, an R-type instruction with rs1=5, rs2=6 gives stall=0.
REQ-036 RAW: issue ADDI with rd=5 (issue_rd_en=1) -> busy_vec[5]=1 next cycle; an ADD with rs1=5 stalls until wb_valid with wb_rd=5.
- With WB_BYPASS=1, stall=0 in the wb cycle.
- With WB_BYPASS=0, stall=0 one cycle later.
REQ-037 Saturation: three LOADs to rd=7 without writeback -> counter=3; a fourth with rd=7 stalls; one wb of rd=7 -> it issues next cycle.
REQ-038 Simultaneous: counter[9]=1; issue to rd=9 together with wb of rd=9 -> counter[9] stays 1 and busy_vec[9] stays 1.
REQ-039 Usage/x0: LUI with any rs fields and all registers busy -> stall=0; an instruction with rd=0 issued -> busy_vec stays 0; ADD with rs1=0 never stalls on x0.
REQ-040 Flush/underflow: with registers 3 and 4 busy, assert flush together with issue rd=8 -> busy_vec=0 next cycle; a later wb of rd=3 -> wb_underflow=1.

Source files
------------

// File: rtl/utils_pkg.sv
// rtl/utils_pkg.sv - shared opcode constants and register-file sizing
package utils_pkg;

  localparam logic [6:0] R_TYPE     = 7'b0110011;
  localparam logic [6:0] I_TYPE     = 7'b0010011;
  localparam logic [6:0] LOAD_TYPE  = 7'b0000011;
  localparam logic [6:0] S_TYPE     = 7'b0100011;
  localparam logic [6:0] B_TYPE     = 7'b1100011;
  localparam logic [6:0] J_TYPE     = 7'b1101111;
  localparam logic [6:0] JALR_TYPE  = 7'b1100111;
  localparam logic [6:0] LUI_TYPE   = 7'b0110111;
  localparam logic [6:0] AUIPC_TYPE = 7'b0010111;

  localparam int NUM_REGS = 32;

endpackage

// File: rtl/reg_scoreboard_rs_enabled.sv
// rtl/reg_scoreboard_rs_enabled.sv - decodes which source registers an opcode reads
module rs_enabled
  import utils_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  output logic       rs1_enable,
  output logic       rs2_enable
);

  logic use_rs1;
  logic use_rs2;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      R_TYPE, S_TYPE, B_TYPE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      I_TYPE, LOAD_TYPE, JALR_TYPE: begin
        use_rs1 = 1'b1;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
    // x0 is hardwired, so reading it can never create a dependency
    rs1_enable = use_rs1 && (rs1 != 5'd0);
    rs2_enable = use_rs2 && (rs2 != 5'd0);
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register pending-write counters with issue hazard check
module reg_scoreboard
  import utils_pkg::*;
#(
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [6:0]  issue_opcode,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_en,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        stall,
  output logic        issue_fire,
  output logic [31:0] busy_vec,
  output logic        wb_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];
  logic             wb_underflow_q;
  logic             wb_underflow_d;

  logic rs1_enable;
  logic rs2_enable;
  logic rs1_hazard;
  logic rs2_hazard;
  logic rd_full;
  logic wb_hit;
  logic inc_en;
  logic dec_en;

  rs_enabled u_rs_enabled (
    .opcode     (issue_opcode),
    .rs1        (issue_rs1),
    .rs2        (issue_rs2),
    .rs1_enable (rs1_enable),
    .rs2_enable (rs2_enable)
  );

  always_comb begin
    // A source whose only outstanding write retires this cycle is forwarded
    rs1_hazard = rs1_enable && (cnt_q[issue_rs1] != '0) &&
                 !((WB_BYPASS != 0) && wb_valid && (wb_rd == issue_rs1) &&
                   (cnt_q[issue_rs1] == CNT_ONE));
    rs2_hazard = rs2_enable && (cnt_q[issue_rs2] != '0) &&
                 !((WB_BYPASS != 0) && wb_valid && (wb_rd == issue_rs2) &&
                   (cnt_q[issue_rs2] == CNT_ONE));
    rd_full    = issue_rd_en && (cnt_q[issue_rd] == CNT_MAX);
    stall      = issue_valid && (rs1_hazard || rs2_hazard || rd_full);
    issue_fire = issue_valid && !stall;
  end

  always_comb begin
    wb_hit         = wb_valid && (wb_rd != 5'd0);
    inc_en         = issue_fire && issue_rd_en && (issue_rd != 5'd0) && !flush;
    dec_en         = wb_hit && (cnt_q[wb_rd] != '0) && !flush;
    wb_underflow_d = wb_underflow_q || (wb_hit && (cnt_q[wb_rd] == '0));
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        cnt_d[i] = '0;
      end else if (inc_en && (issue_rd == 5'(i)) && !(dec_en && (wb_rd == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end else if (dec_en && (wb_rd == 5'(i)) && !(inc_en && (issue_rd == 5'(i)))) begin
        cnt_d[i] = cnt_q[i] - CNT_ONE;
      end
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
      wb_underflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wb_underflow_q <= wb_underflow_d;
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_vec[i] = (cnt_q[i] != '0);
    end
  end

  assign wb_underflow = wb_underflow_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized and directed checks of reg_scoreboard against a counter model
module tb_reg_scoreboard;

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_I     = 7'h13;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_S     = 7'h23;
  localparam logic [6:0] OP_B     = 7'h63;
  localparam logic [6:0] OP_J     = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OPS [9]  = '{OP_R, OP_I, OP_LOAD, OP_S, OP_B, OP_J, OP_JALR, OP_LUI, OP_AUIPC};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv, rd_en, wv, flush;
  logic [6:0]  op;
  logic [4:0]  rs1, rs2, rd, wr;
  logic        s0, f0, uf0, s1, f1, uf1;
  logic [31:0] bv0, bv1;

  int checks   = 0;
  int failures = 0;
  int m [2][32];
  bit muf [2];
  bit es [2];

  always #5 clk = ~clk;

  reg_scoreboard #(.WB_BYPASS(1), .CNT_W(2)) dut_byp (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_opcode(op), .issue_rs1(rs1),
    .issue_rs2(rs2), .issue_rd(rd), .issue_rd_en(rd_en), .wb_valid(wv), .wb_rd(wr),
    .flush(flush), .stall(s0), .issue_fire(f0), .busy_vec(bv0), .wb_underflow(uf0));

  reg_scoreboard #(.WB_BYPASS(0), .CNT_W(2)) dut_nobyp (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv), .issue_opcode(op), .issue_rs1(rs1),
    .issue_rs2(rs2), .issue_rd(rd), .issue_rd_en(rd_en), .wb_valid(wv), .wb_rd(wr),
    .flush(flush), .stall(s1), .issue_fire(f1), .busy_vec(bv1), .wb_underflow(uf1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit reads_rs1(input logic [6:0] o);
    return o inside {OP_R, OP_S, OP_B, OP_I, OP_LOAD, OP_JALR};
  endfunction

  function automatic bit reads_rs2(input logic [6:0] o);
    return o inside {OP_R, OP_S, OP_B};
  endfunction

  function automatic bit src_blocked(input int b, input logic [4:0] r);
    if (r == 0 || m[b][r] == 0) return 1'b0;
    if (b == 0 && wv && wr == r && m[b][r] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_stall(input int b);
    if (!iv) return 1'b0;
    if (reads_rs1(op) && src_blocked(b, rs1)) return 1'b1;
    if (reads_rs2(op) && src_blocked(b, rs2)) return 1'b1;
    return rd_en && (m[b][rd] == 3);
  endfunction

  function automatic logic [31:0] model_busy(input int b);
    logic [31:0] v = '0;
    for (int i = 1; i < 32; i++) v[i] = (m[b][i] != 0);
    return v;
  endfunction

  task automatic check_now();
    #1;
    es[0] = model_stall(0);
    es[1] = model_stall(1);
    chk("stall_byp", s0, es[0]);
    chk("stall_nobyp", s1, es[1]);
    chk("fire_byp", f0, iv && !es[0]);
    chk("fire_nobyp", f1, iv && !es[1]);
    chk("busy_byp", bv0, model_busy(0));
    chk("busy_nobyp", bv1, model_busy(1));
    chk("uf_byp", uf0, muf[0]);
    chk("uf_nobyp", uf1, muf[1]);
  endtask

  task automatic advance();
    bit fire, dec;
    @(posedge clk);
    for (int b = 0; b < 2; b++) begin
      fire = iv && !es[b];
      if (wv && wr != 0 && m[b][wr] == 0) muf[b] = 1'b1;
      if (flush) begin
        for (int i = 0; i < 32; i++) m[b][i] = 0;
      end else begin
        dec = wv && wr != 0 && m[b][wr] > 0;
        if (fire && rd_en && rd != 0) m[b][rd] = m[b][rd] + 1;
        if (dec) m[b][wr] = m[b][wr] - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    check_now();
    advance();
  endtask

  task automatic set_idle();
    iv = 0; op = '0; rs1 = '0; rs2 = '0; rd = '0; rd_en = 0; wv = 0; wr = '0; flush = 0;
  endtask

  task automatic iss(input logic [6:0] o, input int a, input int c, input int d, input bit e);
    iv = 1; op = o; rs1 = 5'(a); rs2 = 5'(c); rd = 5'(d); rd_en = e;
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    chk("rst_busy_byp", bv0, 32'h0);
    chk("rst_busy_nobyp", bv1, 32'h0);
    chk("rst_uf_byp", uf0, 1'b0);
    chk("rst_uf_nobyp", uf1, 1'b0);
    for (int b = 0; b < 2; b++) begin
      muf[b] = 1'b0;
      for (int i = 0; i < 32; i++) m[b][i] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    set_idle();
    rst_n = 0;
    for (int b = 0; b < 2; b++) begin
      muf[b] = 1'b0;
      for (int i = 0; i < 32; i++) m[b][i] = 0;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // leave something busy and an underflow so reset has work to undo
    iss(OP_I, 0, 0, 12, 1); wv = 1; wr = 13; step();
    set_idle();
    do_reset();
    iss(OP_R, 5, 6, 1, 0); #1;
    chk("rst_rtype_stall_byp", s0, 1'b0);
    chk("rst_rtype_stall_nobyp", s1, 1'b0);
    step();

    // read-after-write
    iss(OP_I, 0, 0, 5, 1); step();
    iss(OP_R, 5, 0, 9, 0); #1;
    chk("raw_busy5", bv0[5], 1'b1);
    chk("raw_stall_byp", s0, 1'b1);
    chk("raw_stall_nobyp", s1, 1'b1);
    step();
    step();
    wv = 1; wr = 5; #1;
    chk("raw_wb_stall_byp", s0, 1'b0);
    chk("raw_wb_stall_nobyp", s1, 1'b1);
    step();
    wv = 0; #1;
    chk("raw_late_stall_nobyp", s1, 1'b0);
    step();
    set_idle();

    // saturation
    iss(OP_LOAD, 0, 0, 7, 1); step(); step(); step();
    #1;
    chk("sat_stall", s0, 1'b1);
    chk("sat_busy7", bv0[7], 1'b1);
    step();
    wv = 1; wr = 7; #1;
    chk("sat_wb_still_stall", s0, 1'b1);
    step();
    wv = 0; #1;
    chk("sat_reissue", f0, 1'b1);
    step();
    set_idle(); flush = 1; step(); flush = 0;

    // simultaneous issue and retire of the same register
    iss(OP_LUI, 0, 0, 9, 1); step();
    wv = 1; wr = 9; step();
    set_idle(); #1;
    chk("simul_busy9", bv0[9], 1'b1);
    step();
    wv = 1; wr = 9; step();
    set_idle(); #1;
    chk("simul_drained9", bv0[9], 1'b0);
    step();

    // source usage and x0
    for (int r = 1; r < 32; r++) begin
      iss(OP_LUI, 0, 0, r, 1); step();
    end
    set_idle(); #1;
    chk("all_busy", bv0, 32'hFFFF_FFFE);
    iss(OP_LUI, $urandom_range(1, 31), $urandom_range(1, 31), 0, 0); #1;
    chk("lui_no_stall", s0, 1'b0);
    step();
    iss(OP_R, 0, 0, 0, 1); #1;
    chk("x0_no_stall", s0, 1'b0);
    step();
    set_idle(); #1;
    chk("x0_not_busy", bv0[0], 1'b0);
    flush = 1; step(); flush = 0;

    // flush then retire a flushed write
    iss(OP_I, 0, 0, 3, 1); step();
    iss(OP_I, 0, 0, 4, 1); step();
    iss(OP_I, 0, 0, 8, 1); flush = 1; #1;
    chk("flush_fire", f0, 1'b1);
    step();
    set_idle(); #1;
    chk("flush_cleared", bv0, 32'h0);
    chk("flush_no_uf_yet", uf0, 1'b0);
    wv = 1; wr = 3; step();
    set_idle(); #1;
    chk("flush_underflow", uf0, 1'b1);
    step();

    // randomized traffic on a small register window to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      iv    = ($urandom_range(0, 3) != 0);
      op    = ($urandom_range(0, 9) == 9) ? 7'($urandom) : OPS[$urandom_range(0, 8)];
      rs1   = 5'($urandom_range(0, 7));
      rs2   = 5'($urandom_range(0, 7));
      rd    = 5'($urandom_range(0, 7));
      rd_en = ($urandom_range(0, 3) != 0);
      wv    = ($urandom_range(0, 2) == 0);
      wr    = 5'($urandom_range(1, 7));
      flush = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 299) == 0) do_reset();
      else step();
    end
    set_idle();
    check_now();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
